// File: rtl/sensor_input_conditioner_pkg.sv
// Shared constants for the sensor front end: line indices and the debounce defaults.
// Purely declarative; nothing here holds state or applies backpressure.
package sensor_input_conditioner_pkg;

  localparam int LOW_WATER  = 0;
  localparam int MID_WATER  = 1;
  localparam int HIGH_WATER = 2;
  localparam int EARTH_HUM  = 3;
  localparam int AIR_HUM    = 4;
  localparam int LOW_TEMP   = 5;
  localparam int SELECTOR   = 6;
  localparam int PULSE      = 7;

  localparam int NUM_LINES             = 8;
  localparam int DEFAULT_STABLE_CYCLES = 16;

  // Counter must be able to hold STABLE_CYCLES-1; one spare value keeps STABLE_CYCLES=1 legal.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One sensor line: 2-flop synchroniser, tick-qualified stability counter, level and rise/fall strobes.
// Latency STABLE_CYCLES+1 edges from capture to level; no backpressure, strobes last one cycle.
module debounce_bit
  import sensor_input_conditioner_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic sample_tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int             CW   = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);

  logic          sync_1;
  logic          sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1 <= RESET_VALUE;
      sync_q <= RESET_VALUE;
      level  <= RESET_VALUE;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_q <= sync_1;
      rise   <= 1'b0;
      fall   <= 1'b0;
      // A return to the accepted level wipes all progress, whatever the tick says.
      if (sync_q == level) begin
        cnt <= '0;
      end else if (sample_tick) begin
        if (cnt == LAST) begin
          level <= sync_q;
          cnt   <= '0;
          rise  <= sync_q;
          fall  <= ~sync_q;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign busy = (sync_q != level);

endmodule

// File: rtl/sensor_input_conditioner.sv
// Debounced front end for the field sensor lines: WIDTH independent debounce_bit slices.
// Latency STABLE_CYCLES+1 edges per line; no backpressure, rise/fall/changed are one-cycle strobes.
module sensor_input_conditioner
  import sensor_input_conditioner_pkg::*;
#(
  parameter int               WIDTH         = NUM_LINES,
  parameter int               STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             sample_tick,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             busy
);

  logic [WIDTH-1:0] bit_busy;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_VALUE   (RESET_VALUE[i])
    ) u_debounce (
      .clock       (clock),
      .reset       (reset),
      .raw         (raw_in[i]),
      .sample_tick (sample_tick),
      .level       (level[i]),
      .rise        (rise[i]),
      .fall        (fall[i]),
      .busy        (bit_busy[i])
    );
  end

  // Both terms come straight from flops, so changed is aligned with the strobes.
  assign changed = |(rise | fall);
  assign busy    = |bit_busy;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Scoreboarded bench for sensor_input_conditioner with STABLE_CYCLES=4.
// Stimulus pushes expected strobes; a negedge monitor pops and compares them.
module tb_sensor_input_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw_in = 8'h00;
  logic       sample_tick = 1'b1;
  logic [7:0] level;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       changed;
  logic       busy;

  sensor_input_conditioner #(
    .WIDTH         (8),
    .STABLE_CYCLES (4),
    .RESET_VALUE   (8'h00)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .raw_in      (raw_in),
    .sample_tick (sample_tick),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .changed     (changed),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         at;
    logic [7:0] r;
    logic [7:0] f;
    logic [7:0] l;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
  endtask

  task automatic goto(input int k);
    while (edge_cnt < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_strobe(input int at, input logic [7:0] r, input logic [7:0] f,
                               input logic [7:0] l);
    exp_t e;
    e.at = at;
    e.r  = r;
    e.f  = f;
    e.l  = l;
    sb.push_back(e);
  endtask

  // Monitor: every cycle showing a strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (changed || rise != 8'h00 || fall != 8'h00) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {16'h0, rise, fall}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_edge", edge_cnt, e.at);
        check("strobe_rise", rise, e.r);
        check("strobe_fall", fall, e.f);
        check("strobe_level", level, e.l);
        check("strobe_changed", changed, 1);
      end
    end
  end

  initial begin
    int n;
    int exp_edge;
    int ticks;

    // Reset held two edges with all lines high.
    reset = 1'b1;
    raw_in = 8'hFF;
    sample_tick = 1'b1;
    goto(2);
    check("rst_level", level, 8'h00);
    check("rst_rise", rise, 8'h00);
    check("rst_fall", fall, 8'h00);
    check("rst_changed", changed, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    n = edge_cnt;
    expect_strobe(n + 6, 8'hFF, 8'h00, 8'hFF);
    goto(n + 2);
    check("idle_busy_pending", busy, 1);
    goto(n + 5);
    check("idle_level_not_early", level, 8'h00);
    goto(n + 7);
    check("idle_level_final", level, 8'hFF);
    check("idle_changed_one_cycle", changed, 0);
    check("idle_busy_clear", busy, 0);

    // Drop to 01: seven simultaneous falls.
    n = edge_cnt;
    raw_in = 8'h01;
    expect_strobe(n + 6, 8'h00, 8'hFE, 8'h01);
    goto(n + 8);

    // Falling edge on bit 0.
    n = edge_cnt;
    raw_in = 8'h00;
    expect_strobe(n + 6, 8'h00, 8'h01, 8'h00);
    goto(n + 5);
    check("fall_level_not_early", level, 8'h01);
    goto(n + 8);

    // Three-clock glitch on bit 3 must be discarded.
    n = edge_cnt;
    raw_in = 8'h08;
    goto(n + 3);
    raw_in = 8'h00;
    goto(n + 4);
    check("glitch_busy_during", busy, 1);
    goto(n + 5);
    check("glitch_busy_cleared", busy, 0);
    goto(n + 8);
    check("glitch_level", level, 8'h00);

    // Tick every third edge; bit 7 rises and needs four qualified samples.
    n = edge_cnt;
    raw_in = 8'h80;
    ticks = 0;
    exp_edge = 0;
    for (int k = n + 3; ticks < 4; k++) begin
      if (k % 3 == 0) begin
        ticks++;
        exp_edge = k;
      end
    end
    expect_strobe(exp_edge, 8'h80, 8'h00, 8'h80);
    for (int k = n; k < exp_edge; k++) begin
      goto(k);
      sample_tick = ((k + 1) % 3 == 0);
    end
    check("tick_level_not_early", level, 8'h00);
    check("tick_busy_pending", busy, 1);
    goto(exp_edge);
    sample_tick = 1'b1;
    goto(exp_edge + 2);
    check("tick_level_final", level, 8'h80);

    // Reset while bit 1 has counted to 2.
    n = edge_cnt;
    raw_in = 8'h82;
    goto(n + 4);
    reset = 1'b1;
    goto(n + 5);
    check("midrst_level", level, 8'h00);
    check("midrst_rise", rise, 8'h00);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    expect_strobe(n + 11, 8'h82, 8'h00, 8'h82);
    goto(n + 10);
    check("midrst_restart_not_early", level, 8'h00);
    goto(n + 13);

    // Accept bit 5, then rise bits 0,2 and fall bit 5 together.
    n = edge_cnt;
    raw_in = 8'hA2;
    expect_strobe(n + 6, 8'h20, 8'h00, 8'hA2);
    goto(n + 8);
    n = edge_cnt;
    raw_in = 8'h87;
    expect_strobe(n + 6, 8'h05, 8'h20, 8'h87);
    goto(n + 10);

    check("scoreboard_drained", sb.size(), 0);
    check("final_busy", busy, 0);
    check("final_level", level, 8'h87);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, %0d of %0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
